// File: rtl/bus_driver_arbiter_if.sv
// ============================================================================
// Module      : bus_driver_arbiter_if
// Description : Request/enable bundle between the bus requesters and the
//               round-robin bus driver arbiter.
//               master modport : arbiter side (drives drv_en/owner/busy/timeout)
//               slave modport  : requester side (drives req)
// Signals     : req     [NREQ-1:0]  level request per requester
//               drv_en  [NREQ-1:0]  one-hot-or-zero driver enables
//               owner   [OW-1:0]    index of current owner (valid while busy)
//               busy                any driver enabled
//               timeout             1-cycle pulse on forced release
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_driver_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] drv_en;
  logic [OW-1:0]   owner;
  logic            busy;
  logic            timeout;

  modport master (
    input  req,
    output drv_en,
    output owner,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    input  drv_en,
    input  owner,
    input  busy,
    input  timeout
  );
endinterface

`default_nettype wire

// File: rtl/bus_driver_arbiter.sv
// ============================================================================
// Module      : bus_driver_arbiter
// Description : Round-robin arbiter for a shared tri-state data bus. Enables
//               at most one bus driver per cycle and inserts TURN_CYC idle
//               cycles between consecutive owners so drivers never overlap.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous reset, active-high
//               bus  - bus_driver_arbiter_if.master (req in; drv_en, owner,
//                      busy, timeout out; all outputs registered)
// Parameters  : NREQ     (2..8)   requesters / drivers
//               TURN_CYC (1..7)   idle cycles between owners
//               MAX_HOLD (2..255) owned cycles before forced release
// Options     : BUS_ARB_TIMEOUT_EN - when defined, an owner holding the bus
//               for MAX_HOLD cycles is forcibly released and timeout pulses.
//               When undefined, timeout is tied low and ownership is unbounded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_driver_arbiter #(
  parameter int NREQ     = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_driver_arbiter_if.master bus
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] drv_en_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_q;
  logic            busy_q;
  logic [2:0]      turn_q;

  // Candidate index at distance 'off' past 'base', wrapping at NREQ
  // (NREQ need not be a power of two).
  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return OW'(s);
  endfunction

  // Round-robin search starting just after the last owner. Iterating from
  // the farthest candidate down lets the nearest requester win.
  logic            grant_vld_d;
  logic [OW-1:0]   grant_idx_d;
  logic [NREQ-1:0] grant_oh_d;

  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (bus.req[wrap_idx(last_q, i)]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = wrap_idx(last_q, i);
      end
    end
    grant_oh_d = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_d;
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q;
  logic       timeout_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      drv_en_q  <= '0;
      owner_q   <= '0;
      last_q    <= OW'(NREQ - 1);
      busy_q    <= 1'b0;
      turn_q    <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            drv_en_q <= grant_oh_d;
            owner_q  <= grant_idx_d;
            last_q   <= grant_idx_d;
            busy_q   <= 1'b1;
            state_q  <= OWN;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_q   <= '0;
`endif
          end
        end

        OWN: begin
          // Other requesters are ignored until the owner lets go.
          if (!bus.req[owner_q]) begin
            drv_en_q <= '0;
            busy_q   <= 1'b0;
            turn_q   <= 3'(TURN_CYC);
            state_q  <= TURN;
`ifdef BUS_ARB_TIMEOUT_EN
          end else if (hold_q == HOLD_LAST) begin
            // Forced release; last_q already names this owner, so it drops
            // to lowest priority exactly as in a voluntary release.
            drv_en_q  <= '0;
            busy_q    <= 1'b0;
            turn_q    <= 3'(TURN_CYC);
            timeout_q <= 1'b1;
            state_q   <= TURN;
          end else begin
            hold_q <= hold_q + 8'd1;
`endif
          end
        end

        TURN: begin
          // turn_q == 1 marks the edge closing the last idle cycle.
          if (turn_q == 3'd1) begin
            if (grant_vld_d) begin
              drv_en_q <= grant_oh_d;
              owner_q  <= grant_idx_d;
              last_q   <= grant_idx_d;
              busy_q   <= 1'b1;
              state_q  <= OWN;
`ifdef BUS_ARB_TIMEOUT_EN
              hold_q   <= '0;
`endif
            end else begin
              state_q <= IDLE;
            end
          end else begin
            turn_q <= turn_q - 3'd1;
          end
        end

        default: begin
          drv_en_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.drv_en = drv_en_q;
  assign bus.owner  = owner_q;
  assign bus.busy   = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_driver_arbiter.sv
// ============================================================================
// Module      : tb_bus_driver_arbiter
// Description : Directed self-checking bench for bus_driver_arbiter. Two
//               instances share clk/rst: u_dut_a (TURN_CYC=1) and
//               u_dut_b (TURN_CYC=3). Build with BUS_ARB_TIMEOUT_EN defined
//               to exercise forced release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_driver_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_driver_arbiter_if #(.NREQ(4)) bus_a ();
  bus_driver_arbiter_if #(.NREQ(4)) bus_b ();

  bus_driver_arbiter #(.NREQ(4), .TURN_CYC(1), .MAX_HOLD(16)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  bus_driver_arbiter #(.NREQ(4), .TURN_CYC(3), .MAX_HOLD(16)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare drv_en and busy; owner only matters while the bus is held.
  task automatic check_a(input string tag, input logic [3:0] drv, input logic [1:0] own);
    check({tag, "_drv_en"}, 32'(bus_a.drv_en), 32'(drv));
    check({tag, "_busy"},   32'(bus_a.busy),   32'(|drv));
    if (|drv) check({tag, "_owner"}, 32'(bus_a.owner), 32'(own));
  endtask

  task automatic check_b(input string tag, input logic [3:0] drv, input logic [1:0] own);
    check({tag, "_drv_en"}, 32'(bus_b.drv_en), 32'(drv));
    check({tag, "_busy"},   32'(bus_b.busy),   32'(|drv));
    if (|drv) check({tag, "_owner"}, 32'(bus_b.owner), 32'(own));
  endtask

  // Advance one clock and sample 1 time unit later; invariants every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    check("a_onehot0", 32'($onehot0(bus_a.drv_en)), 32'd1);
    check("b_onehot0", 32'($onehot0(bus_b.drv_en)), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0000;

    // 1. Reset state, then idle with no requests.
    repeat (2) @(posedge clk);
    #1;
    check("rst_drv_en",  32'(bus_a.drv_en),  32'd0);
    check("rst_owner",   32'(bus_a.owner),   32'd0);
    check("rst_busy",    32'(bus_a.busy),    32'd0);
    check("rst_timeout", 32'(bus_a.timeout), 32'd0);
    check("rst_b_owner", 32'(bus_b.owner),   32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_a("idle", 4'b0000, 2'd0);
      check("idle_owner", 32'(bus_a.owner), 32'd0);
    end

    // 2. Single requester 2: 1-cycle grant latency, release on drop.
    bus_a.req = 4'b0100;
    tick();
    check_a("single_grant", 4'b0100, 2'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_a("single_hold", 4'b0100, 2'd2);
    end
    bus_a.req = 4'b0000;
    tick();
    check_a("single_release", 4'b0000, 2'd0);
    tick();
    check_a("single_idle", 4'b0000, 2'd0);

    // 3. All requesting: grants rotate 0,1,2,3,0 with one idle cycle between.
    do_reset();
    bus_a.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_a("rr_grant", 4'b0001 << (k % 4), 2'(k % 4));
      tick();
      check_a("rr_hold1", 4'b0001 << (k % 4), 2'(k % 4));
      tick();
      check_a("rr_hold2", 4'b0001 << (k % 4), 2'(k % 4));
      bus_a.req = 4'b1111 & ~(4'b0001 << (k % 4));
      tick();
      check_a("rr_turn", 4'b0000, 2'd0);
      bus_a.req = 4'b1111;
      tick();
    end
    bus_a.req = 4'b0000;

    // 4. TURN_CYC=3: owner 1 releases while 0 and 3 request -> 3 wins.
    do_reset();
    bus_b.req = 4'b0010;
    tick();
    check_b("t3_grant1", 4'b0010, 2'd1);
    bus_b.req = 4'b1001;
    tick();
    check_b("t3_idle1", 4'b0000, 2'd0);
    tick();
    check_b("t3_idle2", 4'b0000, 2'd0);
    tick();
    check_b("t3_idle3", 4'b0000, 2'd0);
    tick();
    check_b("t3_grant3", 4'b1000, 2'd3);
    bus_b.req = 4'b0000;

    // 5. Asynchronous reset mid-ownership drops drv_en before the next edge.
    do_reset();
    bus_a.req = 4'b0001;
    tick();
    check_a("arst_own", 4'b0001, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_drv_en", 32'(bus_a.drv_en), 32'd0);
    check("arst_busy",   32'(bus_a.busy),   32'd0);
    check("arst_owner",  32'(bus_a.owner),  32'd0);
    check("arst_b_drv",  32'(bus_b.drv_en), 32'd0);
    #1;
    rst = 1'b0;
    bus_a.req = 4'b1000;
    tick();
    check_a("arst_regrant", 4'b1000, 2'd3);
    bus_a.req = 4'b0000;

    // 6. Requester 0 holds with requester 2 waiting.
    do_reset();
    bus_a.req = 4'b0101;
    tick();
    for (int i = 0; i < 16; i++) begin
      check_a("hold_own", 4'b0001, 2'd0);
      check("hold_timeout", 32'(bus_a.timeout), 32'd0);
      tick();
    end
`ifdef BUS_ARB_TIMEOUT_EN
    check_a("to_release", 4'b0000, 2'd0);
    check("to_pulse", 32'(bus_a.timeout), 32'd1);
    tick();
    check_a("to_next", 4'b0100, 2'd2);
    check("to_pulse_end", 32'(bus_a.timeout), 32'd0);
`else
    check_a("noto_keep", 4'b0001, 2'd0);
    check("noto_timeout", 32'(bus_a.timeout), 32'd0);
    tick();
    check_a("noto_keep2", 4'b0001, 2'd0);
    check("noto_timeout2", 32'(bus_a.timeout), 32'd0);
`endif
    bus_a.req = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
